conf_int_add_pipe: RTL and testbench

Parametrised, pipelined, runtime-configurable approximate integer adder. Successor to the combinational configurable adder, and sits in the datapath of the approximate-operator family. A per-level mask zeroes the low `lvl*SEG` operand bits to shorten the effective carry chain. Adds a 2-stage valid/ready pipeline, a drain-then-switch configuration handshake, and an optional error monitor.

---
 rtl/conf_int_add_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_conf_int_add_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_add_pipe.sv
// conf_int_add_pipe: pipelined, runtime-configurable approximate adder.
//
// The active level masks the low lvl*SEG operand bits to zero. The sum is
// computed over two pipeline stages. S1 registers the masked upper halves
// and the low-half sum with its carry. S2 finishes the upper half and
// registers c and out_lvl. Each transaction keeps the level that was
// active when it was accepted.
//
// A level change drains the pipeline first (DRAIN), then switches the
// level and pulses conf_ack (SWITCH), then returns to RUN.
//
// Optional feature macro: CONF_INT_ADD_ERR_MON_EN. When it is defined,
// an exact sum is carried through the pipeline, and the err_clr input is
// added. err_acc accumulates (exact - c) on each output handshake, and
// approx_cnt counts the outputs with out_lvl != 0. Both counters
// saturate. When the macro is undefined, both outputs are tied to zero.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid/in_ready, a, b  input handshake and unsigned operands
//   out_valid/out_ready      output handshake
//   c                        WIDTH+1 bit sum
//   out_lvl                  level used to compute c
//   conf_req, conf_select    level-change request and requested level
//   conf_ack                 one-cycle pulse when the requested level is active
//   busy                     high while draining or switching
//   err_acc, approx_cnt      error monitor outputs
//   err_clr                  synchronous monitor clear (monitor builds only)
module conf_int_add_pipe #(
  parameter int WIDTH     = 32,
  parameter int SEG       = 4,
  parameter int CONF_W    = 4,
  parameter int ERR_ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       c,
  output logic [CONF_W-1:0]    out_lvl,
  input  logic                 conf_req,
  input  logic [CONF_W-1:0]    conf_select,
  output logic                 conf_ack,
  output logic                 busy,
  output logic [ERR_ACC_W-1:0] err_acc,
  output logic [31:0]          approx_cnt
`ifdef CONF_INT_ADD_ERR_MON_EN
  ,
  input  logic                 err_clr
`endif
);

  localparam int unsigned NSEG    = WIDTH / SEG;
  localparam int unsigned MAX_LVL = NSEG - 1;
  localparam int unsigned SEG_U   = SEG;
  localparam int unsigned LO      = WIDTH / 2;
  localparam int unsigned HI      = WIDTH - LO;
  localparam logic [CONF_W-1:0] MAX_LVL_C = CONF_W'(MAX_LVL);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CONF_W-1:0] active_lvl_q, active_lvl_d;
  logic [CONF_W-1:0] pending_q, pending_d;
  logic              ack_q, ack_d;

  logic              s1_valid_q;
  logic [HI-1:0]     s1_ahi_q, s1_bhi_q;
  logic [LO-1:0]     s1_lo_q;
  logic              s1_cy_q;
  logic [CONF_W-1:0] s1_lvl_q;

  logic              s2_valid_q;
  logic [WIDTH:0]    c_q;
  logic [CONF_W-1:0] out_lvl_q;

  logic [CONF_W-1:0] sel_clamped;
  logic [WIDTH-1:0]  mask, a_m, b_m;
  logic [LO:0]       lo_sum;
  logic [HI:0]       hi_sum;
  logic              adv, s1_open, accept;

  function automatic logic [WIDTH-1:0] lvl_mask(input logic [CONF_W-1:0] lvl);
    logic [WIDTH-1:0] m;
    int unsigned cut;
    cut = SEG_U * 32'(lvl);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m[i] = (i >= cut);
    end
    return m;
  endfunction

  assign sel_clamped = (conf_select > MAX_LVL_C) ? MAX_LVL_C : conf_select;
  assign mask        = lvl_mask(active_lvl_q);
  assign a_m         = a & mask;
  assign b_m         = b & mask;
  assign lo_sum      = {1'b0, a_m[LO-1:0]} + {1'b0, b_m[LO-1:0]};
  assign hi_sum      = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q} + (HI+1)'(s1_cy_q);

  // S1 may refill whenever it is empty, even while S2 is stalled.
  assign adv      = !s2_valid_q || out_ready;
  assign s1_open  = !s1_valid_q || adv;
  assign in_ready = (state_q == ST_RUN) && s1_open;
  assign accept   = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign c         = c_q;
  assign out_lvl   = out_lvl_q;
  assign busy      = (state_q != ST_RUN);
  assign conf_ack  = ack_q || (state_q == ST_SWITCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s1_lo_q    <= '0;
      s1_cy_q    <= 1'b0;
      s1_lvl_q   <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      out_lvl_q  <= '0;
    end else begin
      if (s1_open) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_ahi_q <= a_m[WIDTH-1:LO];
          s1_bhi_q <= b_m[WIDTH-1:LO];
          s1_lo_q  <= lo_sum[LO-1:0];
          s1_cy_q  <= lo_sum[LO];
          s1_lvl_q <= active_lvl_q;
        end
      end
      if (adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          c_q       <= {hi_sum, s1_lo_q};
          out_lvl_q <= s1_lvl_q;
        end
      end
    end
  end

  // The first request that differs from the active level is latched into
  // pending. Requests arriving during DRAIN or SWITCH are ignored.
  always_comb begin
    state_d      = state_q;
    active_lvl_d = active_lvl_q;
    pending_d    = pending_q;
    ack_d        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (conf_req) begin
          if (sel_clamped == active_lvl_q) begin
            ack_d = 1'b1;
          end else begin
            pending_d = sel_clamped;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d      = ST_SWITCH;
          active_lvl_d = pending_q;
        end
      end
      ST_SWITCH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      active_lvl_q <= '0;
      pending_q    <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_lvl_q <= active_lvl_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
    end
  end

`ifdef CONF_INT_ADD_ERR_MON_EN
  logic [WIDTH:0]       s1_exact_q, exact_q;
  logic [ERR_ACC_W-1:0] err_acc_q;
  logic [31:0]          approx_cnt_q;
  logic [WIDTH:0]       err_diff;
  logic [ERR_ACC_W:0]   acc_sum;

  assign err_diff = exact_q - c_q;
  assign acc_sum  = {1'b0, err_acc_q} + {1'b0, ERR_ACC_W'(err_diff)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_exact_q   <= '0;
      exact_q      <= '0;
      err_acc_q    <= '0;
      approx_cnt_q <= '0;
    end else begin
      if (accept) begin
        s1_exact_q <= {1'b0, a} + {1'b0, b};
      end
      if (adv && s1_valid_q) begin
        exact_q <= s1_exact_q;
      end
      if (err_clr) begin
        err_acc_q    <= '0;
        approx_cnt_q <= '0;
      end else if (s2_valid_q && out_ready) begin
        err_acc_q <= acc_sum[ERR_ACC_W] ? '1 : acc_sum[ERR_ACC_W-1:0];
        if (out_lvl_q != '0 && approx_cnt_q != '1) begin
          approx_cnt_q <= approx_cnt_q + 32'd1;
        end
      end
    end
  end

  assign err_acc    = err_acc_q;
  assign approx_cnt = approx_cnt_q;
`else
  assign err_acc    = '0;
  assign approx_cnt = '0;
`endif

endmodule

// File: tb/tb_conf_int_add_pipe.sv
// Self-checking bench for conf_int_add_pipe (WIDTH=32, SEG=4).
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge before new values are driven.
module tb_conf_int_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic [32:0] c;
  logic [3:0]  out_lvl;
  logic        conf_req;
  logic [3:0]  conf_select;
  logic        conf_ack, busy;
  logic [47:0] err_acc;
  logic [31:0] approx_cnt;
`ifdef CONF_INT_ADD_ERR_MON_EN
  logic        err_clr;
`endif

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_c_q[$];
  logic [3:0]  exp_l_q[$];

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  sel;
    logic [3:0]  lvl;
    logic [32:0] vc;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  conf_int_add_pipe #(
    .WIDTH(32), .SEG(4), .CONF_W(4), .ERR_ACC_W(48)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .out_lvl(out_lvl),
    .conf_req(conf_req), .conf_select(conf_select), .conf_ack(conf_ack),
    .busy(busy), .err_acc(err_acc), .approx_cnt(approx_cnt)
`ifdef CONF_INT_ADD_ERR_MON_EN
    , .err_clr(err_clr)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_level(input logic [3:0] sel);
    bit got;
    got = 1'b0;
    conf_req = 1'b1; conf_select = sel;
    @(negedge clk);
    conf_req = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (conf_ack) got = 1'b1;
      @(negedge clk);
    end
    check("conf_ack_seen", 64'(got), 64'd1);
  endtask

  task automatic transact(input logic [31:0] ta, input logic [31:0] tb_,
                          output logic [32:0] rc, output logic [3:0] rl);
    bit acc;
    acc = 1'b0;
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("accepted", 64'(acc), 64'd1);
    check("latency_s1_only", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    rc = c; rl = out_lvl;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] rc, held;
    logic [3:0]  rl;
    logic [31:0] ba, bb;
    int accepted, got, acks, bad_ready, outs;
    bit third_acc, seen;

    vt[0] = '{32'h0000FFFF, 32'h00000001, 4'd0,  4'd0, 33'h000010000};
    vt[1] = '{32'h123456FF, 32'h00000001, 4'd2,  4'd2, 33'h012345600};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 4'd7, 33'h1E0000000};
    vt[3] = '{32'hFFFFFFFF, 32'h00000001, 4'd0,  4'd0, 33'h100000000};
    vt[4] = '{32'h0000000F, 32'h00000001, 4'd1,  4'd1, 33'h000000000};
    vt[5] = '{32'h00001234, 32'h00000FFF, 4'd3,  4'd3, 33'h000001000};
    vt[6] = '{32'h80000000, 32'h80000000, 4'd0,  4'd0, 33'h100000000};
    vt[7] = '{32'h0001FFFF, 32'h0000FFFF, 4'd4,  4'd4, 33'h000010000};

    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    conf_req = 1'b0; conf_select = '0;
`ifdef CONF_INT_ADD_ERR_MON_EN
    err_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_out_lvl", 64'(out_lvl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_conf_ack", 64'(conf_ack), 64'd0);
    check("rst_err_acc", 64'(err_acc), 64'd0);
    check("rst_approx_cnt", 64'(approx_cnt), 64'd0);
    rst = 1'b0;
    #1 check("rst_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Table-driven: level, operands, sum
    for (int i = 0; i < 8; i++) begin
      set_level(vt[i].sel);
      transact(vt[i].va, vt[i].vb, rc, rl);
      check($sformatf("vec%0d_c", i), 64'(rc), 64'(vt[i].vc));
      check($sformatf("vec%0d_lvl", i), 64'(rl), 64'(vt[i].lvl));
    end

    // Same-level request (level 4): ack next cycle, no stall
    conf_req = 1'b1; conf_select = 4'd4;
    @(negedge clk);
    conf_req = 1'b0;
    check("same_ack", 64'(conf_ack), 64'd1);
    check("same_busy", 64'(busy), 64'd0);
    check("same_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("same_ack_done", 64'(conf_ack), 64'd0);

    // Request coinciding with an input handshake: the input uses level 4
    conf_req = 1'b1; conf_select = 4'd0;
    a = 32'h00012345; b = 32'h0000FFFF; in_valid = 1'b1;
    check("coinc_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    conf_req = 1'b0; in_valid = 1'b0;
    check("coinc_busy", 64'(busy), 64'd1);
    check("coinc_in_ready_drain", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("coinc_out_valid", 64'(out_valid), 64'd1);
    check("coinc_c", 64'(c), 64'h10000);
    check("coinc_lvl", 64'(out_lvl), 64'd4);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (conf_ack) seen = 1'b1;
      @(negedge clk);
    end
    check("coinc_ack_seen", 64'(seen), 64'd1);

    // Level switch timing from an empty pipeline (0 -> 4)
    conf_req = 1'b1; conf_select = 4'd4;
    @(negedge clk);
    conf_req = 1'b0;
    check("sw_t1_busy", 64'(busy), 64'd1);
    check("sw_t1_in_ready", 64'(in_ready), 64'd0);
    check("sw_t1_ack", 64'(conf_ack), 64'd0);
    @(negedge clk);
    check("sw_t2_ack", 64'(conf_ack), 64'd1);
    check("sw_t2_busy", 64'(busy), 64'd1);
    check("sw_t2_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("sw_t3_ack", 64'(conf_ack), 64'd0);
    check("sw_t3_busy", 64'(busy), 64'd0);
    check("sw_t3_in_ready", 64'(in_ready), 64'd1);

    // Backpressure at level 0
    set_level(4'd0);
    out_ready = 1'b0; accepted = 0; held = '0;
    for (int k = 0; k < 6; k++) begin
      ba = 32'h01010101 * 32'(accepted + 1);
      bb = 32'hF0000000 + 32'(accepted);
      a = ba; b = bb; in_valid = 1'b1;
      if (k == 2) held = c;
      if (k >= 2) begin
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_c_stable", 64'(c), 64'(held));
      end
      if (in_ready) begin
        exp_c_q.push_back({1'b0, ba} + {1'b0, bb});
        exp_l_q.push_back(4'd0);
        accepted++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1; got = 0;
    for (int i = 0; i < 10 && got < 2; i++) begin
      if (out_valid) begin
        if (exp_c_q.size() == 0) check("bp_unexpected_out", 64'd1, 64'd0);
        else begin
          check("bp_c_order", 64'(c), 64'(exp_c_q.pop_front()));
          check("bp_lvl", 64'(out_lvl), 64'(exp_l_q.pop_front()));
        end
        got++;
      end
      @(negedge clk);
    end
    check("bp_outputs", 64'(got), 64'd2);

    // Mid-stream switch 0 -> 3 with two transactions in flight
    exp_c_q.delete(); exp_l_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ba = 32'h00100000 * 32'(k + 1);
      bb = 32'h0000000F + 32'(k);
      a = ba; b = bb; in_valid = 1'b1;
      if (in_ready) begin
        exp_c_q.push_back({1'b0, ba} + {1'b0, bb});
        exp_l_q.push_back(4'd0);
      end
      @(negedge clk);
    end
    conf_req = 1'b1; conf_select = 4'd3;
    a = 32'h0000ABCD; b = 32'h00000FFF; in_valid = 1'b1;
    @(negedge clk);
    conf_select = 4'd5;  // second request while draining
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    conf_req = 1'b0; out_ready = 1'b1;
    acks = 0; bad_ready = 0; outs = 0; third_acc = 1'b0;
    for (int i = 0; i < 30 && outs < 3; i++) begin
      if (conf_ack) acks++;
      if (busy && in_ready) bad_ready++;
      if (out_valid && out_ready) begin
        if (exp_c_q.size() == 0) check("mid_unexpected_out", 64'd1, 64'd0);
        else begin
          check("mid_c", 64'(c), 64'(exp_c_q.pop_front()));
          check("mid_lvl", 64'(out_lvl), 64'(exp_l_q.pop_front()));
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        exp_c_q.push_back(33'h00000A000);
        exp_l_q.push_back(4'd3);
        third_acc = 1'b1;
      end
      @(negedge clk);
      if (third_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("mid_outputs", 64'(outs), 64'd3);
    check("mid_ack_pulses", 64'(acks), 64'd1);
    check("mid_in_ready_while_busy", 64'(bad_ready), 64'd0);

    // Reset during DRAIN with S2 valid
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = 32'h00000700 + 32'(k); b = 32'h00000100; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    conf_req = 1'b1; conf_select = 4'd1;
    @(negedge clk);
    conf_req = 1'b0;
    check("prerst_busy", 64'(busy), 64'd1);
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_c", 64'(c), 64'd0);
    check("midrst_out_lvl", 64'(out_lvl), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("postrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    transact(32'h0000000F, 32'h00000001, rc, rl);
    check("postrst_c", 64'(rc), 64'h10);
    check("postrst_lvl", 64'(rl), 64'd0);

`ifdef CONF_INT_ADD_ERR_MON_EN
    set_level(4'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("mon_clr_err", 64'(err_acc), 64'd0);
    transact(32'h0000000F, 32'h00000001, rc, rl);
    check("mon_c", 64'(rc), 64'd0);
    check("mon_err_acc", 64'(err_acc), 64'h10);
    check("mon_approx_cnt", 64'(approx_cnt), 64'd1);
    out_ready = 1'b0;
    a = 32'h0000000F; b = 32'h00000001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mon_clr_out_valid", 64'(out_valid), 64'd1);
    err_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("mon_clr_hs_err", 64'(err_acc), 64'd0);
    check("mon_clr_hs_cnt", 64'(approx_cnt), 64'd0);
    check("mon_clr_hs_consumed", 64'(out_valid), 64'd0);
`else
    check("nomon_err_acc", 64'(err_acc), 64'd0);
    check("nomon_approx_cnt", 64'(approx_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
